// File: rtl/game_pkg.sv
// Shared types and constants for the game state engine.
// Holds the FSM state encoding and BCD digit geometry used by the top and the score counter.
// Pure declarations: no logic, no latency.
package game_pkg;

  // Game FSM states.
  typedef enum logic [1:0] {
    ST_PLAY     = 2'd0,
    ST_HIT      = 2'd1,
    ST_INVULN   = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_t;

  // Width of one BCD digit and the largest legal digit value.
  localparam int             BCD_W    = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

  // Widths of the lives and hit-index outputs.
  localparam int LIVES_W = 3;
  localparam int IDX_W   = 3;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD accumulator: adds INC on each inc_i, optionally saturating at all nines.
// Latency: value_o updates on the clock edge after inc_i/clr_i; clr_i has priority over inc_i.
// No backpressure: every request is absorbed in the cycle it is presented.
module bcd_counter
  import game_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int INC      = 1,
  parameter int SATURATE = 1
) (
  input  logic                    Clk,
  input  logic                    ResetN,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [BCD_W*DIGITS-1:0] value_o
);

  localparam logic [BCD_W*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

  logic [BCD_W*DIGITS-1:0] value_q, value_d;
  logic [BCD_W*DIGITS-1:0] sum;
  logic [4:0]              carry;
  logic [4:0]              dig;
  logic                    overflow;

  // Ripple a decimal add of INC through the digits; carry out of the top digit flags overflow.
  always_comb begin
    sum   = value_q;
    carry = 5'(INC);
    dig   = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dig = {1'b0, value_q[d*BCD_W +: BCD_W]} + carry;
      if (dig > 5'd9) begin
        sum[d*BCD_W +: BCD_W] = 4'(dig - 5'd10);
        carry                 = 5'd1;
      end else begin
        sum[d*BCD_W +: BCD_W] = dig[BCD_W-1:0];
        carry                 = 5'd0;
      end
    end
    overflow = (carry != 5'd0);
  end

  // Select the next value: clear wins, then increment (held at all nines on overflow if saturating).
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i) begin
      value_d = (overflow && (SATURATE != 0)) ? ALL_NINES : sum;
    end
  end

  // Score register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/game_state_engine.sv
// Game rules engine: barrel collision detection, lives, invulnerability window and BCD score.
// Latency: a colliding tick shows on hitPulse/lives two cycles later; score one cycle after jumpPulse.
// No backpressure: tick, jumpPulse and restart are single-cycle events consumed immediately.
module game_state_engine
  import game_pkg::*;
#(
  parameter int N_BARRELS    = 4,
  parameter int LIVES_INIT   = 3,
  parameter int SCORE_DIGITS = 3,
  parameter int INVULN_TICKS = 16,
  parameter int HIT_W        = 10,
  parameter int HIT_H        = 5
) (
  input  logic                          Clk,
  input  logic                          ResetN,
  input  logic                          tick,
  input  logic [7:0]                    playerX,
  input  logic [6:0]                    playerY,
  input  logic [8*N_BARRELS-1:0]        barrelX,
  input  logic [7*N_BARRELS-1:0]        barrelY,
  input  logic [N_BARRELS-1:0]          barrelValid,
  input  logic                          jumpPulse,
  input  logic                          restart,
  output logic [LIVES_W-1:0]            lives,
  output logic [BCD_W*SCORE_DIGITS-1:0] score,
  output logic                          hitPulse,
  output logic [IDX_W-1:0]              hitIndex,
  output logic                          invuln,
  output logic                          gameOver
);

  state_t             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic               hit_pulse_q, hit_pulse_d;
  logic               invuln_q, invuln_d;
  logic               gameover_q, gameover_d;
  logic [7:0]         cnt_q, cnt_d;

  // Hitbox bounds, one bit wider than the coordinates so a box near the edge never wraps.
  logic [8:0] x_lo, x_hi;
  logic [7:0] y_lo, y_hi;
  assign x_lo = {1'b0, playerX};
  assign x_hi = {1'b0, playerX} + 9'(HIT_W);
  assign y_lo = {1'b0, playerY};
  assign y_hi = {1'b0, playerY} + 8'(HIT_H);

  logic [N_BARRELS-1:0] coll;

  for (genvar i = 0; i < N_BARRELS; i++) begin : g_coll
    logic [8:0] bx;
    logic [7:0] by;
    assign bx      = {1'b0, barrelX[8*i +: 8]};
    assign by      = {1'b0, barrelY[7*i +: 7]};
    assign coll[i] = barrelValid[i] && (bx >= x_lo) && (bx < x_hi) && (by >= y_lo) && (by < y_hi);
  end

  logic             any_coll;
  logic [IDX_W-1:0] coll_idx;

  // Priority encoder: report the lowest-numbered colliding channel.
  always_comb begin
    any_coll = |coll;
    coll_idx = '0;
    for (int k = N_BARRELS - 1; k >= 0; k--) begin
      if (coll[k]) begin
        coll_idx = IDX_W'(k);
      end
    end
  end

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    hit_idx_d   = hit_idx_q;
    hit_pulse_d = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      ST_PLAY: begin
        if (tick && any_coll) begin
          state_d   = ST_HIT;
          hit_idx_d = coll_idx;
        end
      end
      ST_HIT: begin
        hit_pulse_d = 1'b1;
        lives_d     = lives_q - 3'd1;
        if (lives_q <= 3'd1) begin
          lives_d = '0;
          state_d = ST_GAMEOVER;
        end else begin
          state_d = ST_INVULN;
          cnt_d   = 8'(INVULN_TICKS);
        end
      end
      ST_INVULN: begin
        // Collisions are ignored here; only the window counter advances.
        if (tick) begin
          if (cnt_q <= 8'd1) begin
            cnt_d   = '0;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_GAMEOVER: begin
        if (restart) begin
          state_d = ST_PLAY;
          lives_d = LIVES_W'(LIVES_INIT);
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
    invuln_d   = (state_d == ST_INVULN);
    gameover_d = (state_d == ST_GAMEOVER);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q     <= ST_PLAY;
      lives_q     <= LIVES_W'(LIVES_INIT);
      hit_idx_q   <= '0;
      hit_pulse_q <= 1'b0;
      invuln_q    <= 1'b0;
      gameover_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      hit_idx_q   <= hit_idx_d;
      hit_pulse_q <= hit_pulse_d;
      invuln_q    <= invuln_d;
      gameover_q  <= gameover_d;
      cnt_q       <= cnt_d;
    end
  end

  // Points count in every live state; a restart from game over clears the score.
  logic score_inc, score_clr;
  assign score_inc = jumpPulse && (state_q != ST_GAMEOVER);
  assign score_clr = restart && (state_q == ST_GAMEOVER);

  bcd_counter #(
    .DIGITS  (SCORE_DIGITS),
    .INC     (1),
    .SATURATE(1)
  ) u_score (
    .Clk    (Clk),
    .ResetN (ResetN),
    .clr_i  (score_clr),
    .inc_i  (score_inc),
    .value_o(score)
  );

  assign lives    = lives_q;
  assign hitPulse = hit_pulse_q;
  assign hitIndex = hit_idx_q;
  assign invuln   = invuln_q;
  assign gameOver = gameover_q;

endmodule

// File: doc/game_state_engine.md
GAME_STATE_ENGINE -- requirements
Module: game_state_engine

Interface
REQ-001 SHALL have parameter N_BARRELS, default 4, number of barrel channels checked (1..8).
REQ-002 SHALL have parameter LIVES_INIT, default 3, lives loaded at reset or restart (1..7).
REQ-003 SHALL have parameter SCORE_DIGITS, default 3, number of BCD score digits (1..4).
REQ-004 SHALL have parameter INVULN_TICKS, default 16, frame ticks of invulnerability after a hit (1..255).
REQ-005 SHALL have parameter HIT_W, default 10, player hitbox width in pixels; parameter HIT_H, default 5, hitbox height.
REQ-006 Clk  in  1  system clock; all state updates on rising edge.
REQ-007 ResetN  in  1  reset, synchronous, active-low.
REQ-008 tick  in  1  one-cycle frame-enable pulse; collision checks and timers advance only on tick.
REQ-009 playerX  in  8 and playerY  in  7  player hitbox top-left corner.
REQ-010 barrelX  in  8*N_BARRELS and barrelY  in  7*N_BARRELS  packed barrel positions, channel i at bits [8i+7:8i] and [7i+6:7i].
REQ-011 barrelValid  in  N_BARRELS  channel i is active; inactive channels never collide.
REQ-012 jumpPulse  in  1  one-cycle "barrel cleared" event; adds one point.
REQ-013 restart  in  1  one-cycle request to start a new game; honoured only in GAMEOVER.
REQ-014 lives  out  3  remaining lives.
REQ-015 score  out  4*SCORE_DIGITS  packed BCD score, digit 0 least significant.
REQ-016 hitPulse  out  1  one-cycle pulse when a hit is registered; hitIndex  out  3  lowest colliding channel index, held until the next hit.
REQ-017 invuln  out  1  high while invulnerable; gameOver  out  1  high in GAMEOVER.

Function
REQ-018 FSM SHALL have four states: PLAY, HIT, INVULN, GAMEOVER.
REQ-019 Collision for channel i SHALL be barrelValid[i] and playerX <= bx < playerX+HIT_W and playerY <= by < playerY+HIT_H, with sums computed 1 bit wider (no wrap).
REQ-020 In PLAY, on tick with any collision, SHALL go to HIT next cycle and latch hitIndex as the lowest colliding index.
REQ-021 In HIT (exactly one cycle) SHALL assert hitPulse and decrement lives; if lives was 1, SHALL go to GAMEOVER, else to INVULN, loading the invulnerability counter with INVULN_TICKS.
REQ-022 In INVULN, the counter SHALL decrement on each tick and the FSM SHALL return to PLAY on the tick where the counter reaches 0; collisions SHALL be ignored.
REQ-023 Collisions on a non-tick cycle SHALL be ignored in every state.
REQ-024 jumpPulse SHALL add 1 to score by BCD carry across all digits in PLAY, HIT and INVULN, and SHALL be ignored in GAMEOVER.
REQ-025 Score SHALL saturate at all digits 9; it SHALL NOT wrap.
REQ-026 jumpPulse coincident with a colliding tick SHALL apply both the point and the hit.
REQ-027 In GAMEOVER, restart SHALL reload lives=LIVES_INIT, score=0, counter=0, and go to PLAY next cycle; restart in other states SHALL be ignored.
REQ-028 Outputs SHALL be registered; the hit is visible on hitPulse/lives 2 cycles after the colliding tick.

Reset
REQ-029 On ResetN low at a clock edge: state=PLAY, lives=LIVES_INIT, score=0, hitPulse=0, hitIndex=0, invuln=0, gameOver=0, counter=0.
REQ-030 Reset SHALL override tick, jumpPulse and restart in the same cycle, including mid-HIT and mid-INVULN.

Structure
REQ-031 State encodings and the BCD digit width SHALL live in the shared package game_pkg.
REQ-032 A sub-module bcd_counter (parametrised by digits, increment, saturate) SHALL implement the score.
REQ-033 The collision compare SHALL be a generate loop over N_BARRELS feeding a priority encoder.

Verification
REQ-034 Player (20,30), barrel0 (25,32) valid, tick -> hitPulse 2 cycles later, lives 3->2, hitIndex=0, invuln=1.
REQ-035 After a hit, a collision on every tick for 16 ticks -> no further hit; the first colliding tick after the counter expires -> lives 2->1.
REQ-036 lives=1, collision on tick -> gameOver=1, lives=0; jumpPulse ignored; restart -> lives=3, score=000, PLAY.
REQ-037 Score 999 with jumpPulse -> stays 999; score 099 with jumpPulse -> 100.
REQ-038 Barrels 1 and 3 both collide on the same tick as jumpPulse -> hitIndex=1, one life lost, score +1.
REQ-039 Barrel at bx=playerX+HIT_W (edge), and a valid=0 overlapping barrel -> no hit; ResetN low during INVULN -> all REQ-029 values next cycle.
